tube_share_arb: RTL and testbench

Time-shares the 8-digit multiplexed seven-segment tube between two display requesters. It owns the digit-scan timing, decodes each requester's hex word into active-low segment codes, and arbitrates ownership only on frame boundaries, so a requester's frame is never split. It sits between application blocks (ID banner, counters, status) and the board's `posi`/`tube` pins, replacing per-application scan logic.

---
 rtl/tube_share_arb.sv | 197 +++++++++++++++++++
 tb/tb_tube_share_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tube_share_arb.sv
// tube_share_arb: time-shares an 8-digit multiplexed seven-segment tube between two
// requesters, switching owner only on frame boundaries. Optional feature macro: TUBE_BLANK_EN.
module tube_share_arb #(
  parameter int SCAN_DIV = 100000,
  parameter int DWELL    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic [7:0]  dp0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic [7:0]  dp1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  posi,
  output logic [7:0]  tube,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DW_W  = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DW_W-1:0]  DW_MAX   = DW_W'(DWELL);
`ifdef TUBE_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_FROM = CNT_W'(SCAN_DIV - (SCAN_DIV >> 3));
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } st_t;

  // hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  st_t              st_q, st_d;
  logic [DW_W-1:0]  dwell_q, dwell_d, dwell_inc;
  logic             ptr_q, ptr_d;
  logic [31:0]      snap_data_q, snap_data_d;
  logic [7:0]       snap_dp_q, snap_dp_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [7:0]       posi_q, posi_d, tube_q, tube_d;
  logic             tick, boundary;
  logic [3:0]       cur_nib;
  logic             cur_dp;

  // Scan timing: prescaler and digit index
  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (dig_q == 3'd7);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    dig_d = tick ? dig_q + 3'd1 : dig_q;
  end

  // Arbiter: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      st_q    <= ST_IDLE;
      dwell_q <= '0;
      ptr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      st_q    <= st_d;
      dwell_q <= dwell_d;
      ptr_q   <= ptr_d;
    end
  end

  assign dwell_inc = (dwell_q == DW_MAX) ? dwell_q : dwell_q + DW_W'(1);

  // Arbiter: next state; ptr_q names the requester favoured on the next tie
  always_comb begin
    st_d    = st_q;
    dwell_d = dwell_q;
    ptr_d   = ptr_q;
    if (boundary) begin
      case (st_q)
        ST_IDLE: begin
          if (req0 && req1)  st_d = ptr_q ? ST_OWN1 : ST_OWN0;
          else if (req0)     st_d = ST_OWN0;
          else if (req1)     st_d = ST_OWN1;
        end
        ST_OWN0: begin
          if (!req0) begin
            st_d = req1 ? ST_OWN1 : ST_IDLE;
          end else begin
            dwell_d = dwell_inc;
            if ((dwell_inc == DW_MAX) && req1) st_d = ST_OWN1;
          end
        end
        ST_OWN1: begin
          if (!req1) begin
            st_d = req0 ? ST_OWN0 : ST_IDLE;
          end else begin
            dwell_d = dwell_inc;
            if ((dwell_inc == DW_MAX) && req0) st_d = ST_OWN0;
          end
        end
        default: st_d = ST_IDLE;
      endcase
      if (st_d != st_q) begin
        dwell_d = '0;
        if (st_d == ST_OWN0) ptr_d = 1'b1;
        if (st_d == ST_OWN1) ptr_d = 1'b0;
      end
    end
  end

  // Frame buffer: latched for the incoming owner at the boundary only
  always_comb begin
    snap_data_d = snap_data_q;
    snap_dp_d   = snap_dp_q;
    if (boundary) begin
      if (st_d == ST_OWN0) begin
        snap_data_d = data0;
        snap_dp_d   = dp0;
      end else if (st_d == ST_OWN1) begin
        snap_data_d = data1;
        snap_dp_d   = dp1;
      end
    end
  end

  always_ff @(posedge clk) begin
    snap_data_q <= snap_data_d;
    snap_dp_q   <= snap_dp_d;
  end

  // Arbiter/scan outputs, registered one cycle behind state and digit
  assign cur_nib = snap_data_q[{dig_q, 2'b00} +: 4];
  assign cur_dp  = snap_dp_q[dig_q];

  always_comb begin
    gnt0_d = (st_q == ST_OWN0);
    gnt1_d = (st_q == ST_OWN1);
    posi_d = 8'hFF;
    tube_d = 8'hFF;
    if (st_q != ST_IDLE) begin
      posi_d = ~(8'd1 << dig_q);
      tube_d = {~cur_dp, hex7(cur_nib)};
`ifdef TUBE_BLANK_EN
      if (cnt_q >= BLANK_FROM) posi_d = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      posi_q <= 8'hFF;
      tube_q <= 8'hFF;
    end else begin
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      posi_q <= posi_d;
      tube_q <= tube_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign posi       = posi_q;
  assign tube       = tube_q;
  assign frame_done = boundary;

endmodule

// File: tb/tb_tube_share_arb.sv
// Self-checking bench for tube_share_arb (SCAN_DIV=8, DWELL=2): per-cycle scoreboard
// against a reference model plus table-driven decode vectors and hand-timed sequences.
`timescale 1ns/1ps
module tb_tube_share_arb;
  localparam int SD = 8;
  localparam int DW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic [7:0]  dp0 = '0, dp1 = '0;
  logic        gnt0, gnt1, frame_done;
  logic [7:0]  posi, tube;

  tube_share_arb #(.SCAN_DIV(SD), .DWELL(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .dp0(dp0),
    .req1(req1), .data1(data1), .dp1(dp1),
    .gnt0(gnt0), .gnt1(gnt1), .posi(posi), .tube(tube),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic [7:0] posi;
    logic [7:0] tube;
    logic       fd;
  } exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [63:0] t;   // expected tube per digit, digit k at [8k+7:8k]
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  logic [6:0]  seg_tab [16];
  int          m_cnt, m_dig, m_st, m_dw, m_ptr;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  bit          m_on = 0;
  exp_t        m_out;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, got, want, cyc_n);
    end
  endtask

  // Reference model: advances one clock using the inputs held across the edge
  task automatic model_step();
    exp_t nx;
    int   ns;
    logic [3:0] nib;
    if (rst) begin
      m_cnt = 0; m_dig = 0; m_st = 0; m_dw = 0; m_ptr = 0;
      nx.g0 = 0; nx.g1 = 0; nx.posi = 8'hFF; nx.tube = 8'hFF; nx.fd = 0;
      m_out = nx;
      m_on = 1;
      return;
    end
    nx.g0 = (m_st == 1);
    nx.g1 = (m_st == 2);
    nx.posi = 8'hFF;
    nx.tube = 8'hFF;
    if (m_st != 0) begin
      nx.posi = ~(8'h01 << m_dig);
`ifdef TUBE_BLANK_EN
      if (m_cnt >= SD - SD / 8) nx.posi = 8'hFF;
`endif
      nib = m_data[m_dig*4 +: 4];
      nx.tube = {~m_dp[m_dig], seg_tab[nib]};
    end
    if (m_cnt == SD - 1 && m_dig == 7) begin
      ns = m_st;
      if (m_st == 0) begin
        if (req0 && req1) ns = (m_ptr == 1) ? 2 : 1;
        else if (req0) ns = 1;
        else if (req1) ns = 2;
      end else begin
        logic mine, other;
        mine  = (m_st == 1) ? req0 : req1;
        other = (m_st == 1) ? req1 : req0;
        if (!mine) ns = other ? 3 - m_st : 0;
        else begin
          m_dw = (m_dw + 1 > DW) ? DW : m_dw + 1;
          if (m_dw >= DW && other) ns = 3 - m_st;
        end
      end
      if (ns != m_st) begin
        m_dw = 0;
        if (ns != 0) m_ptr = (ns == 1) ? 1 : 0;
      end
      m_st = ns;
      if (ns == 1) begin m_data = data0; m_dp = dp0; end
      if (ns == 2) begin m_data = data1; m_dp = dp1; end
    end
    if (m_cnt == SD - 1) begin
      m_cnt = 0;
      m_dig = (m_dig + 1) % 8;
    end else m_cnt++;
    nx.fd = (m_cnt == SD - 1 && m_dig == 7);
    m_out = nx;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst || m_on) begin
      model_step();
      sb.push_back(m_out);
    end
    #1;
    cyc_n++;
  endtask

  task automatic run_to(input int c);
    while (cyc_n < c) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    cyc_n = 1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_gnt0", gnt0, e.g0);
      chk("sb_gnt1", gnt1, e.g1);
      chk("sb_posi", posi, e.posi);
      chk("sb_tube", tube, e.tube);
      chk("sb_frame_done", frame_done, e.fd);
      chk("sb_gnt_mutex", gnt0 & gnt1, 1'b0);
    end
  end

  vec_t vt [3];

  initial begin
    logic [7:0] ep;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vt[0] = '{32'h76543210, 8'h00,
              {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}};
    vt[1] = '{32'hFEDCBA98, 8'h01,
              {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h00}};
    vt[2] = '{32'h01234567, 8'hF0,
              {8'h40, 8'h79, 8'h24, 8'h30, 8'h99, 8'h92, 8'h82, 8'hF8}};

    // Reset with no requester: blank display, periodic frame_done
    do_reset();
    chk("rst_posi", posi, 8'hFF);
    chk("rst_tube", tube, 8'hFF);
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_fd", frame_done, 1'b0);
    run_to(63);  chk("fd_63", frame_done, 1'b0);
    run_to(64);  chk("fd_64", frame_done, 1'b1);
    run_to(65);  chk("fd_65", frame_done, 1'b0);
    run_to(128); chk("fd_128", frame_done, 1'b1);
    run_to(130);
    chk("idle_posi", posi, 8'hFF);
    chk("idle_tube", tube, 8'hFF);
    chk("idle_gnt", {gnt1, gnt0}, 2'b00);

    // Decode vectors, each from a fresh reset with requester 0 alone
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; req1 = 1'b0;
      data0 = vt[i].data; dp0 = vt[i].dp;
      do_reset();
      run_to(65); chk("dec_gnt0_pre", gnt0, 1'b0);
      run_to(66); chk("dec_gnt0_rise", gnt0, 1'b1);
      for (int k = 0; k < 8; k++) begin
        run_to(66 + 8 * k + 3);
        ep = ~(8'h01 << k);
        chk("dec_posi", posi, ep);
        chk("dec_tube", tube, vt[i].t[8*k +: 8]);
      end
    end

    // Contention from reset: requester 0 first, then alternation every DWELL frames
    req0 = 1'b1; req1 = 1'b1;
    data0 = 32'h11111111; data1 = 32'h22222222; dp0 = 8'h00; dp1 = 8'h00;
    do_reset();
    run_to(66);  chk("cont_66", {gnt1, gnt0}, 2'b01);
    run_to(193); chk("cont_193", {gnt1, gnt0}, 2'b01);
    run_to(194); chk("cont_194", {gnt1, gnt0}, 2'b10);
    run_to(197); chk("cont_tube1", tube, 8'hA4);
    run_to(321); chk("cont_321", {gnt1, gnt0}, 2'b10);
    run_to(322); chk("cont_322", {gnt1, gnt0}, 2'b01);
    run_to(450); chk("cont_450", {gnt1, gnt0}, 2'b10);

    // Release mid-frame: old snapshot holds, hand-over at the boundary, then IDLE
    req0 = 1'b1; req1 = 1'b0;
    data0 = 32'h76543210; dp0 = 8'h00;
    data1 = 32'hFEDCBA98; dp1 = 8'h01;
    do_reset();
    run_to(90);
    req0 = 1'b0; data0 = 32'hFFFFFFFF; req1 = 1'b1;
    run_to(100); chk("rel_old_tube", tube, 8'h99);
    chk("rel_gnt_hold", {gnt1, gnt0}, 2'b01);
    run_to(129); chk("rel_129", {gnt1, gnt0}, 2'b01);
    run_to(130); chk("rel_130", {gnt1, gnt0}, 2'b10);
    run_to(133);
    chk("rel_new_posi", posi, 8'hFE);
    chk("rel_new_tube", tube, 8'h00);
    run_to(140); req1 = 1'b0;
    run_to(193);
    chk("rel_last_gnt", {gnt1, gnt0}, 2'b10);
    chk("rel_last_tube", tube, 8'h8E);
    run_to(194);
    chk("rel_idle_posi", posi, 8'hFF);
    chk("rel_idle_tube", tube, 8'hFF);
    chk("rel_idle_gnt", {gnt1, gnt0}, 2'b00);

    // Reset in the middle of an owned frame
    req0 = 1'b1; req1 = 1'b0; data0 = 32'h76543210; dp0 = 8'h00;
    do_reset();
    run_to(100);
    chk("mid_pre_gnt", gnt0, 1'b1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_posi", posi, 8'hFF);
    chk("mid_rst_tube", tube, 8'hFF);
    chk("mid_rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("mid_rst_fd", frame_done, 1'b0);
    rst = 1'b0;
    cyc_n = 1;
    run_to(65); chk("mid_regrant_65", gnt0, 1'b0);
    run_to(66); chk("mid_regrant_66", gnt0, 1'b1);
    run_to(69); chk("mid_regrant_tube", tube, 8'hC0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
